// File: rtl/uart_pkg.sv
// Shared definitions for the arbitrated UART transmitter: frame states,
// data width and the default baud divider.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;  // 115200 baud at 100 MHz

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// Serializes one byte as start bit, 8 data bits LSB first and stop bit.
// A start pulse in IDLE latches the byte; done pulses in the last STOP cycle.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [DATA_BITS-1:0] byte_i,
  output logic                 tx_o,
  output logic                 done_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 tx_q, tx_d;
  logic                 wrap;

  assign wrap = (cnt_q == CNT_MAX);

  // Next-state logic: baud counting, bit sequencing and the next line level.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    done_o  = 1'b0;

    if (state_q != ST_IDLE) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        idx_d = '0;
        if (start_i) begin
          byte_d  = byte_i;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (wrap) begin
          state_d = ST_DATA;
          idx_d   = '0;
          tx_d    = byte_q[0];
        end
      end
      ST_DATA: begin
        if (wrap) begin
          if (idx_q == LAST_BIT) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = byte_q[idx_q + 3'd1];
          end
        end
      end
      ST_STOP: begin
        if (wrap) begin
          state_d = ST_IDLE;
          done_o  = 1'b1;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State registers; tx is registered so the line never glitches.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_o = tx_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Arbitration and the valid/ready handshake live here; framing is delegated.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  localparam int GW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [DATA_BITS*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx_out,
  output logic                         busy,
  output logic [GW-1:0]                grant_id
);

  logic                 busy_q;
  logic [GW-1:0]        last_grant_q;
  logic [GW-1:0]        grant_id_q;
  logic [GW-1:0]        sel;
  logic                 found;
  logic [NUM_REQ-1:0]   ready_vec;
  logic                 handshake;
  logic [DATA_BITS-1:0] sel_byte;
  logic                 frame_done;

  // Round-robin search starting one past the last winner, plus the handshake.
  always_comb begin
    logic [GW:0]   sum;
    logic [GW-1:0] cand;
    sel       = '0;
    found     = 1'b0;
    ready_vec = '0;
    sel_byte  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      sum = {1'b0, last_grant_q} + (GW+1)'(off);
      if (sum >= (GW+1)'(NUM_REQ)) begin
        sum = sum - (GW+1)'(NUM_REQ);
      end
      cand = sum[GW-1:0];
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == sel) begin
        sel_byte     = req_data[i*DATA_BITS +: DATA_BITS];
        ready_vec[i] = found && !busy_q && !rst;
      end
    end
    handshake = |(ready_vec & req_valid);
  end

  // Grant bookkeeping: a handshake claims the line until the frame completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= 1'b0;
      last_grant_q <= GW'(NUM_REQ - 1);
      grant_id_q   <= '0;
    end else if (handshake) begin
      busy_q       <= 1'b1;
      last_grant_q <= sel;
      grant_id_q   <= sel;
    end else if (frame_done) begin
      busy_q       <= 1'b0;
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serializer (
    .clk     (clk),
    .rst     (rst),
    .start_i (handshake),
    .byte_i  (sel_byte),
    .tx_o    (tx_out),
    .done_o  (frame_done)
  );

  assign req_ready = ready_vec;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a frame-level model checks every output every
// cycle; directed sequences pin the model with hand-computed expectations.
module tb_uart_tx_arbiter;

  localparam int NR    = 4;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          tx_out;
  logic          busy;
  logic [1:0]    grant_id;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_out    (tx_out),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Frame view: idle, or busy at position m_pos (0..FRAME-1) of a frame
  // carrying m_byte. Line level follows from position/CPB alone.
  bit            m_busy = 1'b0;
  int            m_pos  = 0;
  logic [7:0]    m_byte = '0;
  int            m_last = NR - 1;
  int            m_gid  = 0;
  logic [NR-1:0] m_hs   = '0;

  always @(negedge clk) begin
    logic [NR-1:0] exp_ready;
    logic          exp_tx;
    int            sel;
    exp_ready = '0;
    sel = -1;
    if (!rst && !m_busy) begin
      for (int off = 1; off <= NR; off++) begin
        int k;
        k = (m_last + off) % NR;
        if (sel < 0 && req_valid[k]) sel = k;
      end
    end
    if (sel >= 0) exp_ready[sel] = 1'b1;

    if (!m_busy)                exp_tx = 1'b1;
    else if (m_pos < CPB)       exp_tx = 1'b0;
    else if (m_pos >= 9 * CPB)  exp_tx = 1'b1;
    else                        exp_tx = m_byte[m_pos / CPB - 1];

    check("req_ready", req_ready, exp_ready);
    check("busy", busy, m_busy);
    check("tx_out", tx_out, exp_tx);
    check("grant_id", grant_id, m_gid);

    m_hs = exp_ready & req_valid;
    if (rst) begin
      m_busy = 1'b0;
      m_pos  = 0;
      m_last = NR - 1;
      m_gid  = 0;
    end else if (m_busy) begin
      m_pos++;
      if (m_pos == FRAME) begin
        m_busy = 1'b0;
        m_pos  = 0;
      end
    end else if (sel >= 0) begin
      m_busy = 1'b1;
      m_pos  = 0;
      m_byte = req_data[8*sel +: 8];
      m_last = sel;
      m_gid  = sel;
    end
  end

  // Watches requester 1 while it is meant to be starved of ready.
  bit track_r1 = 1'b0;
  int r1_seen  = 0;
  always @(negedge clk) if (track_r1 && req_ready[1]) r1_seen++;

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int max, output int id, output int t);
    id = -1;
    t  = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (|(req_ready & req_valid)) begin
        for (int k = 0; k < NR; k++) if (req_ready[k]) id = k;
        t = cyc;
        break;
      end
    end
    if (id < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL handshake_timeout at cycle %0d: no handshake within %0d cycles", cyc, max);
    end
  endtask

  task automatic wait_idle(input int max);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!busy) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_timeout at cycle %0d: busy stuck for %0d cycles", cyc, max);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         id, t;
    int         ids[4];
    int         ts[4];
    logic       tx_s[0:44];
    logic [9:0] pat;
    int         busy_cnt, rdy_cnt;
    logic [7:0] d_bytes[3];

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;

    // Reset state.
    repeat (3) step();
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_tx", tx_out, 1'b1);
    check("rst_ready", req_ready, 4'b0000);
    check("rst_grant", grant_id, 2'd0);
    step();
    rst = 1'b0;

    // Single frame of 0x55 from requester 0.
    req_data[7:0] = 8'h55;
    req_valid     = 4'b0001;
    wait_hs(20, id, t);
    check("b_grant", id, 0);
    step();
    req_valid = '0;
    busy_cnt  = 0;
    rdy_cnt   = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      tx_s[i] = tx_out;
      busy_cnt += int'(busy);
      rdy_cnt  += int'(|req_ready);
    end
    pat = 10'b1010101010;
    for (int k = 0; k < 10; k++) check("b_line_bit", tx_s[4*k+2], pat[k]);
    check("b_busy_cycles", busy_cnt, 40);
    check("b_extra_ready", rdy_cnt, 0);
    check("b_idle_after", tx_s[40], 1'b1);

    // All four valid after reset: grants rotate 0,1,2,3, 41 cycles apart.
    rst = 1'b1;
    step();
    rst       = 1'b0;
    req_data  = 32'hA3A2A1A0;
    req_valid = 4'hF;
    for (int n = 0; n < 4; n++) begin
      wait_hs(100, id, t);
      ids[n] = id;
      ts[n]  = t;
    end
    step();
    req_valid = '0;
    for (int n = 0; n < 4; n++) check("c_grant_order", ids[n], n);
    for (int n = 1; n < 4; n++) check("c_frame_spacing", ts[n] - ts[n-1], 41);

    // Requester 2 alone, three consecutive bytes.
    d_bytes = '{8'h11, 8'h22, 8'h33};
    req_data[23:16] = d_bytes[0];
    req_valid       = 4'b0100;
    for (int n = 0; n < 3; n++) begin
      wait_hs(100, id, t);
      ids[n] = id;
      ts[n]  = t;
      step();
      if (n < 2) req_data[23:16] = d_bytes[n+1];
    end
    req_valid = '0;
    for (int n = 0; n < 3; n++) check("d_grant", ids[n], 2);
    for (int n = 1; n < 3; n++) check("d_spacing", ts[n] - ts[n-1], 41);

    // Reset 13 cycles into a frame of 0x0F aborts it.
    wait_idle(100);
    step();
    req_data[7:0] = 8'h0F;
    req_valid     = 4'b0001;
    wait_hs(20, id, t);
    step();
    req_valid = '0;
    repeat (13) step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("e_abort_tx", tx_out, 1'b1);
    check("e_abort_busy", busy, 1'b0);
    step();
    rst       = 1'b0;
    req_valid = 4'hF;
    wait_hs(20, id, t);
    check("e_first_after_rst", id, 0);
    step();
    req_valid = '0;

    // Requester 1 drops mid-frame while 3 holds: 3 wins, 1 never sees ready.
    wait_idle(100);
    step();
    req_data[7:0] = 8'h3C;
    req_valid     = 4'b0001;
    wait_hs(20, id, t);
    step();
    req_data[15:8]  = 8'h99;
    req_data[31:24] = 8'h77;
    req_valid       = 4'b1010;
    track_r1        = 1'b1;
    repeat (10) step();
    req_valid = 4'b1000;
    wait_hs(100, id, t);
    check("f_next_grant", id, 3);
    step();
    req_valid = '0;
    track_r1  = 1'b0;
    check("f_r1_ready", r1_seen, 0);

    // Randomized traffic; the model checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      step();
      rst = ($urandom % 600 == 0);
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && m_hs[i]) begin
          if ($urandom % 2 == 0) req_valid[i] = 1'b0;
          else req_data[8*i +: 8] = 8'($urandom);
        end else if (req_valid[i]) begin
          if (m_busy && ($urandom % 8 == 0)) req_valid[i] = 1'b0;
        end else begin
          req_data[8*i +: 8] = 8'($urandom);
          if ($urandom % 4 == 0) req_valid[i] = 1'b1;
        end
      end
    end
    rst       = 1'b0;
    req_valid = '0;
    wait_idle(100);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
